// File: rtl/sparse_pos_packer.sv
// Streams a ternary sparse polynomial and packs +1 / -1 positions into the multiplier's pos RAM.
// Optional SPARSE_POS_CODE_CHECK_EN: reserved code 10 sets err (otherwise it is a silent zero).
module sparse_pos_packer #(
    parameter  int N         = 1024,
    parameter  int H         = 384,
    parameter  int CORE_NUM  = 2,
    localparam int POS_WIDTH = $clog2(N),
    localparam int AW        = $clog2(H / CORE_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          coeff_valid,
    input  logic [1:0]                    coeff_in,
    output logic                          coeff_ready,
    output logic                          ram_pos_wr_en,
    output logic [AW-1:0]                 ram_pos_wr_addr,
    output logic [POS_WIDTH*CORE_NUM-1:0] ram_pos_data_in,
    output logic                          done,
    output logic                          err
);
    localparam int WPH = H / (2 * CORE_NUM);
    localparam int SW  = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
    localparam logic [AW-1:0]        WORD_END  = AW'(WPH);
    localparam logic [SW-1:0]        LAST_SLOT = SW'(CORE_NUM - 1);
    localparam logic [POS_WIDTH-1:0] LAST_IDX  = POS_WIDTH'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;
    typedef logic [CORE_NUM-1:0][POS_WIDTH-1:0] word_t;

    state_t               r_state, w_next;
    logic [POS_WIDTH-1:0] r_idx;
    logic [SW-1:0]        r_slot [2];
    logic [AW-1:0]        r_word [2];
    word_t                r_sr   [2];
    word_t                w_full_word [2];
    logic [1:0]           w_push, w_ovf, w_part;
    logic                 w_xfer, w_end_bad;
    logic                 r_wr_en, r_err;
    logic [AW-1:0]        r_wr_addr;
    word_t                r_wr_data;

    // Packer 0 (+1) owns the lower half of the RAM, packer 1 (-1) the upper half.
    function automatic logic [AW-1:0] word_addr(input int k, input logic [AW-1:0] w);
        return (k == 0) ? w : w + WORD_END;
    endfunction

    assign coeff_ready = (r_state == S_LOAD);
    assign w_xfer      = coeff_valid && coeff_ready;
    assign w_push[0]   = w_xfer && (coeff_in == 2'b01);
    assign w_push[1]   = w_xfer && (coeff_in == 2'b11);
    assign w_end_bad   = (r_word[0] != WORD_END) || (r_word[1] != WORD_END);

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_ovf[k]       = w_push[k] && (r_word[k] == WORD_END);
            w_part[k]      = (r_slot[k] != '0);
            w_full_word[k] = r_sr[k];
            w_full_word[k][CORE_NUM-1] = r_idx;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  if (w_xfer && (r_idx == LAST_IDX)) w_next = S_FLUSH;
            // Stay until both partial words have drained so done trails the last write.
            S_FLUSH: if (w_part == 2'b00) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                r_slot[k] <= '0;
                r_word[k] <= '0;
                r_sr[k]   <= '0;
            end
        end else begin
            r_wr_en <= 1'b0;
            if ((r_state == S_IDLE) && start) begin
                r_idx <= '0;
                r_err <= 1'b0;
                for (int k = 0; k < 2; k++) begin
                    r_slot[k] <= '0;
                    r_word[k] <= '0;
                    r_sr[k]   <= '0;
                end
            end
            if (w_xfer) r_idx <= r_idx + 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (w_ovf[k]) begin
                    r_err <= 1'b1;
                end else if (w_push[k]) begin
                    if (r_slot[k] == LAST_SLOT) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= word_addr(k, r_word[k]);
                        r_wr_data <= w_full_word[k];
                        r_word[k] <= r_word[k] + 1'b1;
                        r_slot[k] <= '0;
                        r_sr[k]   <= '0;
                    end else begin
                        r_sr[k][r_slot[k]] <= r_idx;
                        r_slot[k]          <= r_slot[k] + 1'b1;
                    end
                end
            end
`ifdef SPARSE_POS_CODE_CHECK_EN
            if (w_xfer && (coeff_in == 2'b10)) r_err <= 1'b1;
`endif
            if (r_state == S_FLUSH) begin
                if (w_end_bad) r_err <= 1'b1;
                // Slot registers are cleared on every write, so unused slots go out as zero.
                if (w_part[0]) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= word_addr(0, r_word[0]);
                    r_wr_data <= r_sr[0];
                    r_slot[0] <= '0;
                    r_sr[0]   <= '0;
                end else if (w_part[1]) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= word_addr(1, r_word[1]);
                    r_wr_data <= r_sr[1];
                    r_slot[1] <= '0;
                    r_sr[1]   <= '0;
                end
            end
        end
    end

    assign ram_pos_wr_en   = r_wr_en;
    assign ram_pos_wr_addr = r_wr_addr;
    assign ram_pos_data_in = r_wr_data;
    assign done            = (r_state == S_DONE);
    assign err             = r_err;
endmodule
